wb_cmd_master: RTL

Wishbone classic single-transfer master (initiator) driving register slaves on the DSP Wishbone bus. It accepts one read or write command at a time on a simple valid/ready local port and runs a single classic cycle on the bus. It handles ack, err and rty responses, bounded retry and a no-response timeout, and returns read data plus a completion status. It is the bus-facing end of test sequencers and DSP control logic that program slave register banks.

---
 rtl/wb_cmd_master.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic single-transfer master. Takes one read or write command
// at a time from a valid/ready local port and runs one classic cycle on the
// bus. It handles err/rty/ack responses (priority err > rty > ack), a bounded
// number of retries and a no-response timeout. It reports completion with a
// one-cycle rsp_valid_o pulse and a status code.
//
// Ports
//   wb_clk, wb_rst        clock (rising edge) and asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake; accept on valid & ready at an edge
//   cmd_we_i/adr_i/dat_i/sel_i  command fields (write flag, address, data, lanes)
//   rsp_valid_o           one-cycle completion pulse
//   rsp_dat_o             read data, updated only by an acked read
//   rsp_status_o          00 ok, 01 err, 10 retry exhausted, 11 timeout
//   wb_adr_o/dat_o/sel_o/we_o  registered copies of the accepted command
//   wb_cyc_o, wb_stb_o    bus cycle / strobe, always equal
//   wb_cti_o, wb_bte_o    tied to classic cycle / linear burst
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i  slave response
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [aw-1:0]   cmd_adr_i,
    input  logic [dw-1:0]   cmd_dat_i,
    input  logic [dw/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    output logic [dw-1:0]   rsp_dat_o,
    output logic [1:0]      rsp_status_o,
    output logic [aw-1:0]   wb_adr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);

    localparam int          SW         = dw / 8;
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_LAST = 4'(MAX_RETRY);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_RETRY   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_BUS        = 2'd1,
        S_RETRY_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_cmd_ready;
    logic            r_cyc;
    logic            r_rsp_valid;
    logic [dw-1:0]   r_rsp_dat;
    logic [1:0]      r_rsp_status;
    logic [aw-1:0]   r_adr;
    logic [dw-1:0]   r_dat;
    logic [SW-1:0]   r_sel;
    logic            r_we;
    logic [15:0]     r_to_cnt;
    logic [3:0]      r_retry_cnt;

    logic            w_accept;
    logic            w_done;
    logic [1:0]      w_status_next;
    logic            w_capture;
    logic            w_retry_inc;
    logic            w_to_clr;
    logic            w_to_inc;

    // Next-state and per-edge control decisions.
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_done        = 1'b0;
        w_status_next = r_rsp_status;
        w_capture     = 1'b0;
        w_retry_inc   = 1'b0;
        w_to_clr      = 1'b0;
        w_to_inc      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // r_cmd_ready is low in IDLE only for the reset-release cycle.
                if (cmd_valid_i && r_cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUS;
                end
            end

            S_BUS: begin
                if (wb_err_i) begin
                    w_done        = 1'b1;
                    w_status_next = ST_ERR;
                    w_state_next  = S_IDLE;
                end else if (wb_rty_i) begin
                    if (r_retry_cnt == RETRY_LAST) begin
                        w_done        = 1'b1;
                        w_status_next = ST_RETRY;
                        w_state_next  = S_IDLE;
                    end else begin
                        w_retry_inc  = 1'b1;
                        w_to_clr     = 1'b1;
                        w_state_next = S_RETRY_WAIT;
                    end
                end else if (wb_ack_i) begin
                    w_done        = 1'b1;
                    w_status_next = ST_OK;
                    w_capture     = ~r_we;
                    w_state_next  = S_IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_done        = 1'b1;
                    w_status_next = ST_TIMEOUT;
                    w_state_next  = S_IDLE;
                end else begin
                    w_to_inc = 1'b1;
                end
            end

            S_RETRY_WAIT: begin
                w_state_next = S_BUS;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register and all registered outputs. cyc/stb and ready are
    // derived from the next state so they change on the same edge as it.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_cyc        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_to_cnt     <= '0;
            r_retry_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= (w_state_next == S_IDLE);
            r_cyc       <= (w_state_next == S_BUS);
            r_rsp_valid <= w_done;

            if (w_done) begin
                r_rsp_status <= w_status_next;
            end
            if (w_capture) begin
                r_rsp_dat <= wb_dat_i;
            end

            if (w_accept) begin
                r_adr       <= cmd_adr_i;
                r_dat       <= cmd_dat_i;
                r_sel       <= cmd_sel_i;
                r_we        <= cmd_we_i;
                r_to_cnt    <= '0;
                r_retry_cnt <= '0;
            end else begin
                if (w_to_clr) begin
                    r_to_cnt <= '0;
                end else if (w_to_inc) begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                end
                if (w_retry_inc) begin
                    r_retry_cnt <= r_retry_cnt + 4'd1;
                end
            end
        end
    end

    assign cmd_ready_o  = r_cmd_ready;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_dat_o    = r_rsp_dat;
    assign rsp_status_o = r_rsp_status;
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = r_dat;
    assign wb_sel_o     = r_sel;
    assign wb_we_o      = r_we;
    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_cyc;
    assign wb_cti_o     = 3'b000;
    assign wb_bte_o     = 2'b00;

endmodule
